sdio_data_tx: RTL

- Device-side SDIO read-data transmitter: sends one data block from the function to the host on DAT lines.
- Frame is start bit, payload, per-line CRC16, end bit.
- Complements the receive path of the SDIO data PHY; sits between the function/FIFO byte source and the FPGA DAT pad drivers.
- Supports SD4 (4 lines, one nibble per clk) and SD1 (DAT0 only, one bit per clk), SDR only.

---
 rtl/sdio_data_tx.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sdio_data_tx.sv
// sdio_data_tx: device-side SDIO read-data block transmitter (SD1/SD4, SDR) with per-line CRC16.
module sdio_data_tx #(
  parameter int CRC_BITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sd1_phy,
  input  logic       i_activate,
  input  logic [9:0] i_data_count,
  input  logic       i_data_rdy,
  input  logic [7:0] i_data_rd_data,
  output logic       o_data_rd_stb,
  output logic       o_busy,
  output logic       o_finished,
  output logic       o_underrun,
  output logic       o_sdio_data_dir,
  output logic [3:0] o_sdio_data_out
);
  localparam int CW = $clog2(CRC_BITS);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_CRC, S_STOP, S_FIN} state_t;
  state_t r_state, w_next;
  logic                r_sd1, r_dir, r_busy, r_fin, r_underrun;
  logic [9:0]          r_last, r_idx;
  logic [2:0]          r_bit;
  logic [7:0]          r_byte;
  logic [CW-1:0]       r_cnt;
  logic [3:0]          r_out;
  logic [CRC_BITS-1:0] r_crc [4];
  logic                w_last_cyc, w_last_byte, w_fetch, w_drive;
  logic [3:0]          w_bits, w_crc_bits, w_out;

  function automatic logic [CRC_BITS-1:0] crc_step(input logic [CRC_BITS-1:0] c, input logic b);
    return {c[CRC_BITS-2:0], 1'b0} ^ ((c[CRC_BITS-1] ^ b) ? CRC_BITS'(16'h1021) : '0);
  endfunction

  // The state runs one cycle ahead of the registered bus: each state computes what the pads show next.
  assign w_last_cyc    = r_sd1 ? (r_bit == 3'd7) : (r_bit == 3'd1);
  assign w_last_byte   = r_idx == r_last;
  assign w_fetch       = i_activate && (r_state == S_START || (r_state == S_DATA && w_last_cyc && !w_last_byte));
  assign w_drive       = i_activate && (r_state inside {S_START, S_DATA, S_CRC, S_STOP});
  assign w_bits        = r_sd1 ? {3'b111, r_byte[3'd7 - r_bit]} : (r_bit[0] ? r_byte[3:0] : r_byte[7:4]);
  assign w_crc_bits    = r_sd1 ? {3'b111, r_crc[0][CRC_BITS-1]}
                               : {r_crc[3][CRC_BITS-1], r_crc[2][CRC_BITS-1], r_crc[1][CRC_BITS-1], r_crc[0][CRC_BITS-1]};
  assign o_data_rd_stb   = w_fetch && i_data_rdy;
  assign o_busy          = r_busy;
  assign o_finished      = r_fin;
  assign o_underrun      = r_underrun;
  assign o_sdio_data_dir = r_dir;
  assign o_sdio_data_out = r_out;

  always_comb begin
    w_next = r_state;
    w_out  = 4'hF;
    case (r_state)
      S_IDLE:  w_next = S_START;
      S_START: begin
        w_next = S_DATA;
        w_out  = r_sd1 ? 4'hE : 4'h0;
      end
      S_DATA: begin
        w_next = (w_last_cyc && w_last_byte) ? S_CRC : S_DATA;
        w_out  = w_bits;
      end
      S_CRC: begin
        w_next = (r_cnt == CW'(CRC_BITS - 1)) ? S_STOP : S_CRC;
        w_out  = w_crc_bits;
      end
      default: w_next = S_FIN;
    endcase
    if (!i_activate) begin
      w_next = S_IDLE;
      w_out  = 4'hF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out      <= 4'hF;
      r_dir      <= 1'b0;
      r_busy     <= 1'b0;
      r_fin      <= 1'b0;
      r_underrun <= 1'b0;
      r_sd1      <= 1'b0;
      r_last     <= '0;
      r_idx      <= '0;
      r_bit      <= '0;
      r_byte     <= '0;
      r_cnt      <= '0;
      for (int i = 0; i < 4; i++) r_crc[i] <= '0;
    end else begin
      r_out  <= w_out;
      r_dir  <= w_drive;
      r_busy <= w_drive;
      r_fin  <= i_activate && r_state == S_FIN;
      if (w_fetch) begin
        r_byte     <= i_data_rdy ? i_data_rd_data : 8'h00;
        r_underrun <= r_underrun | !i_data_rdy;
      end
      case (r_state)
        S_IDLE: begin
          r_underrun <= 1'b0;
          r_sd1      <= i_sd1_phy;
          r_last     <= (i_data_count == 10'd0) ? 10'd511 : i_data_count - 10'd1;
          r_idx      <= '0;
          r_bit      <= '0;
          r_cnt      <= '0;
          for (int i = 0; i < 4; i++) r_crc[i] <= '0;
        end
        S_DATA: begin
          for (int i = 0; i < 4; i++) if (!r_sd1 || i == 0) r_crc[i] <= crc_step(r_crc[i], w_bits[i]);
          r_bit <= w_last_cyc ? 3'd0 : r_bit + 3'd1;
          if (w_last_cyc) r_idx <= r_idx + 10'd1;
        end
        S_CRC: begin
          for (int i = 0; i < 4; i++) r_crc[i] <= r_crc[i] << 1;
          r_cnt <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule
